// File: rtl/nn_mem_pkg.sv
// Shared memory-system widths, types and fetch FSM encoding for the
// weight/input fetch path.
package nn_mem_pkg;

    localparam int unsigned W_ADDR_LEN = 20;
    localparam int unsigned X_ADDR_LEN = 10;
    localparam int unsigned W_SEL_LEN  = 2;
    localparam int unsigned X_SEL_LEN  = 2;
    localparam int unsigned PACK       = 8;
    localparam int unsigned NEURON_LEN = 10;
    localparam int unsigned BEAT_LEN   = X_ADDR_LEN - 3;
    localparam int unsigned K_LEN      = $clog2(PACK) + 1;

    typedef logic [W_ADDR_LEN-1:0] w_addr_t;
    typedef logic [X_ADDR_LEN-1:0] x_addr_t;
    typedef logic [W_SEL_LEN-1:0]  w_sel_t;
    typedef logic [X_SEL_LEN-1:0]  x_sel_t;
    typedef logic [NEURON_LEN-1:0] neuron_t;
    typedef logic [BEAT_LEN-1:0]   beat_t;
    typedef logic [PACK-1:0]       pack_t;
    typedef logic [K_LEN-1:0]      k_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

    typedef struct packed {
        w_sel_t  w_bank;
        x_sel_t  x_bank;
        neuron_t n_neurons;
        beat_t   x_beats;
    } fetch_cmd_t;

    // A layer with no neurons or no beats finishes without touching memory.
    function automatic logic cmd_empty(input fetch_cmd_t c);
        return (c.n_neurons == '0) || (c.x_beats == '0);
    endfunction

endpackage

// File: rtl/wx_fetch_ctrl_if.sv
// Command, memory-read and beat-output signals of the weight/input fetch
// controller; master is the controller, slave is its environment.
interface wx_fetch_ctrl_if;
    import nn_mem_pkg::*;

    logic    start;
    w_sel_t  w_bank;
    x_sel_t  x_bank;
    neuron_t n_neurons;
    beat_t   x_beats;

    logic    w_rq;
    w_addr_t w_addr;
    w_sel_t  w_sel;
    logic    w_data;

    logic    x_rq;
    x_addr_t x_addr;
    x_sel_t  x_sel;
    logic    x_data;

    logic    out_valid;
    logic    out_ready;
    pack_t   out_w;
    pack_t   out_x;
    logic    out_last;

    logic    busy;
    logic    done;

    modport master (
        input  start, w_bank, x_bank, n_neurons, x_beats,
        input  w_data, x_data, out_ready,
        output w_rq, w_addr, w_sel, x_rq, x_addr, x_sel,
        output out_valid, out_w, out_x, out_last, busy, done
    );

    modport slave (
        output start, w_bank, x_bank, n_neurons, x_beats,
        output w_data, x_data, out_ready,
        input  w_rq, w_addr, w_sel, x_rq, x_addr, x_sel,
        input  out_valid, out_w, out_x, out_last, busy, done
    );

endinterface

// File: rtl/wx_fetch_ctrl_bit_packer.sv
// PACK-bit serial-to-parallel register: bits shift in from the top so the
// first captured bit ends up in bit 0 after PACK captures.
module bit_packer
    import nn_mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  logic  d,
    output pack_t q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {d, q[PACK-1:1]};
        end
    end

endmodule

// File: rtl/wx_fetch_ctrl.sv
// Layer fetch controller: streams one bit per cycle from weight and input
// memories and presents them as PACK-bit beats with a valid/ready handshake.
module wx_fetch_ctrl
    import nn_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    wx_fetch_ctrl_if.master  bus
);

    localparam k_t K_FULL = k_t'(PACK);
    localparam k_t K_LAST = k_t'(PACK - 1);

    fetch_state_e state;
    fetch_cmd_t   cmd;
    fetch_cmd_t   new_cmd;
    k_t           k;
    neuron_t      neuron_idx;
    beat_t        beat_idx;
    logic         rq_d;

    logic         w_rq;
    logic         x_rq;
    w_addr_t      w_addr;
    x_addr_t      x_addr;
    logic         out_valid;
    logic         out_last;
    logic         busy;
    logic         done;

    logic         pack_clr;
    logic         pack_en;

    assign new_cmd = '{w_bank:    bus.w_bank,
                       x_bank:    bus.x_bank,
                       n_neurons: bus.n_neurons,
                       x_beats:   bus.x_beats};

    // Packers restart on every accepted start and every beat handshake.
    assign pack_clr = ((state == ST_IDLE) && bus.start) ||
                      ((state == ST_HOLD) && bus.out_ready);
    // rq_d marks the cycle a requested bit is on the data lines; reset clears
    // it so a bit returning just after reset is dropped.
    assign pack_en  = (state == ST_READ) && rq_d;

    bit_packer u_pack_w (
        .clk (clk),
        .rst (rst),
        .clr (pack_clr),
        .en  (pack_en),
        .d   (bus.w_data),
        .q   (bus.out_w)
    );

    bit_packer u_pack_x (
        .clk (clk),
        .rst (rst),
        .clr (pack_clr),
        .en  (pack_en),
        .d   (bus.x_data),
        .q   (bus.out_x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd        <= '0;
            k          <= '0;
            neuron_idx <= '0;
            beat_idx   <= '0;
            rq_d       <= 1'b0;
            w_rq       <= 1'b0;
            x_rq       <= 1'b0;
            w_addr     <= '0;
            x_addr     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rq_d <= w_rq;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cmd  <= new_cmd;
                        busy <= 1'b1;
                        if (cmd_empty(new_cmd)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_READ;
                            k          <= '0;
                            neuron_idx <= '0;
                            beat_idx   <= '0;
                            w_addr     <= '0;
                            x_addr     <= '0;
                            w_rq       <= 1'b1;
                            x_rq       <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (k == K_FULL) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_last  <= (beat_idx == cmd.x_beats - beat_t'(1));
                    end else begin
                        k      <= k + k_t'(1);
                        w_addr <= w_addr + w_addr_t'(1);
                        x_addr <= x_addr + x_addr_t'(1);
                        if (k == K_LAST) begin
                            w_rq <= 1'b0;
                            x_rq <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        k         <= '0;
                        if (out_last) begin
                            // Input vector restarts per neuron; weights run on.
                            x_addr   <= '0;
                            beat_idx <= '0;
                            if (neuron_idx == cmd.n_neurons - neuron_t'(1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                neuron_idx <= neuron_idx + neuron_t'(1);
                                state      <= ST_READ;
                                w_rq       <= 1'b1;
                                x_rq       <= 1'b1;
                            end
                        end else begin
                            beat_idx <= beat_idx + beat_t'(1);
                            state    <= ST_READ;
                            w_rq     <= 1'b1;
                            x_rq     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.w_rq      = w_rq;
    assign bus.x_rq      = x_rq;
    assign bus.w_addr    = w_addr;
    assign bus.x_addr    = x_addr;
    assign bus.w_sel     = cmd.w_bank;
    assign bus.x_sel     = cmd.x_bank;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

// File: tb/tb_wx_fetch_ctrl.sv
// Bench for wx_fetch_ctrl: bit-level memory model plus a beat/address
// reference computed directly from the layer geometry.
module tb_wx_fetch_ctrl;
    import nn_mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wx_fetch_ctrl_if bus();

    wx_fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int          mem_mode;
    int unsigned mem_seed;

    int unsigned w_log[$], x_log[$], ws_log[$], xs_log[$];
    int          rq_bad;

    pack_t got_w[$], got_x[$];
    logic  got_last[$];
    int    first_valid, hs_first, done_cyc, done_cnt, stall_seen, stall_err, timeout;
    logic  post_done, post_busy;

    pack_t       exp_w[$], exp_x[$];
    logic        exp_last[$];
    int unsigned exp_wa[$], exp_xa[$];

    // Memory contents: 0 all ones, 1 alternating (even addresses = 1), else hashed.
    function automatic logic mem_bit(input int unsigned bank, input int unsigned addr, input bit is_w);
        int unsigned h;
        case (mem_mode)
            0: return 1'b1;
            1: return ~addr[0];
            default: begin
                h = (addr * 32'd2654435761) ^ (bank * 32'd40503) ^ mem_seed ^ (is_w ? 32'h5bd1e995 : 32'h0);
                h = h ^ (h >> 13);
                return h[17] ^ h[5];
            end
        endcase
    endfunction

    // Read data appears one cycle after a request; otherwise lines carry noise.
    always @(posedge clk) begin
        bus.w_data <= bus.w_rq ? mem_bit(32'(bus.w_sel), 32'(bus.w_addr), 1'b1) : 1'($urandom);
        bus.x_data <= bus.x_rq ? mem_bit(32'(bus.x_sel), 32'(bus.x_addr), 1'b0) : 1'($urandom);
    end

    always @(negedge clk) begin
        if (bus.w_rq === 1'b1) begin
            w_log.push_back(32'(bus.w_addr));
            ws_log.push_back(32'(bus.w_sel));
        end
        if (bus.x_rq === 1'b1) begin
            x_log.push_back(32'(bus.x_addr));
            xs_log.push_back(32'(bus.x_sel));
        end
        if ((bus.w_rq === 1'b1 || bus.x_rq === 1'b1) &&
            (bus.out_valid === 1'b1 || bus.done === 1'b1 || bus.busy !== 1'b1 || rst === 1'b1))
            rq_bad++;
        if (bus.w_rq !== bus.x_rq)
            rq_bad++;
    end

    function automatic void build_model(input int unsigned n, input int unsigned xb,
                                        input int unsigned wb, input int unsigned xbk);
        pack_t       w, x;
        int unsigned wa, xa;
        exp_w.delete(); exp_x.delete(); exp_last.delete(); exp_wa.delete(); exp_xa.delete();
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned j = 0; j < xb; j++) begin
                for (int unsigned b = 0; b < PACK; b++) begin
                    wa = (i * xb * PACK + j * PACK + b) % (32'd1 << W_ADDR_LEN);
                    xa = j * PACK + b;
                    w[b] = mem_bit(wb, wa, 1'b1);
                    x[b] = mem_bit(xbk, xa, 1'b0);
                    exp_wa.push_back(wa);
                    exp_xa.push_back(xa);
                end
                exp_w.push_back(w);
                exp_x.push_back(x);
                exp_last.push_back(j == xb - 1);
            end
        end
    endfunction

    // Issues one start and plays consumer until done; records what it saw.
    task automatic run_fetch(input int unsigned n, input int unsigned xb, input int unsigned wb,
                             input int unsigned xbk, input int ready_pct, input int stall_beat,
                             input bit spam);
        pack_t   hw, hx;
        logic    hl, holding;
        w_addr_t ha;
        x_addr_t hxa;
        int      cyc, nstall;
        w_log.delete(); x_log.delete(); ws_log.delete(); xs_log.delete();
        got_w.delete(); got_x.delete(); got_last.delete();
        rq_bad = 0; first_valid = -1; hs_first = -1; done_cyc = -1; done_cnt = 0;
        stall_seen = 0; stall_err = 0; timeout = 0; holding = 1'b0; nstall = 0;
        hw = '0; hx = '0; hl = 1'b0; ha = '0; hxa = '0;
        bus.start     = 1'b1;
        bus.n_neurons = neuron_t'(n);
        bus.x_beats   = beat_t'(xb);
        bus.w_bank    = w_sel_t'(wb);
        bus.x_bank    = x_sel_t'(xbk);
        bus.out_ready = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.start = (spam && bus.busy === 1'b1) ? 1'($urandom) : 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                break;
            end
            if (cyc > 4000) begin
                timeout = 1;
                break;
            end
            if (bus.out_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                if (holding) begin
                    stall_seen++;
                    if (bus.out_w !== hw || bus.out_x !== hx || bus.out_last !== hl ||
                        bus.w_addr !== ha || bus.x_addr !== hxa)
                        stall_err++;
                end
                if (got_w.size() == stall_beat && nstall < 5) begin
                    bus.out_ready = 1'b0;
                    nstall++;
                end else begin
                    bus.out_ready = (int'($urandom_range(99)) < ready_pct);
                end
                if (bus.out_ready) begin
                    got_w.push_back(bus.out_w);
                    got_x.push_back(bus.out_x);
                    got_last.push_back(bus.out_last);
                    if (hs_first < 0) hs_first = cyc;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    hw = bus.out_w; hx = bus.out_x; hl = bus.out_last;
                    ha = bus.w_addr; hxa = bus.x_addr;
                end
            end else begin
                holding = 1'b0;
                bus.out_ready = 1'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        post_done = bus.done;
        post_busy = bus.busy;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({bus.w_rq, bus.x_rq, bus.w_addr, bus.x_addr, bus.w_sel, bus.x_sel, bus.out_valid,
             bus.out_w, bus.out_x, bus.out_last, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got w_rq=%b x_rq=%b w_addr=%h x_addr=%h out_valid=%b out_w=%h busy=%b done=%b, expected all 0",
                     bus.w_rq, bus.x_rq, bus.w_addr, bus.x_addr, bus.out_valid, bus.out_w, bus.busy, bus.done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b out_valid=%b expected 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_single;
        int bad_sel;
        mem_mode = 0;
        build_model(1, 1, 2, 0);
        run_fetch(1, 1, 2, 0, 100, -1, 1'b0);
        checks++;
        if (first_valid != 10) begin
            errors++; $display("FAIL single_latency: got out_valid on cycle %0d expected 10", first_valid);
        end
        checks++;
        if (got_w.size() != 1) begin
            errors++; $display("FAIL single_beats: got %0d beats expected 1", got_w.size());
        end else begin
            checks++;
            if (got_w[0] !== 8'hFF || got_x[0] !== 8'hFF || got_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_data: got out_w=%h out_x=%h last=%b expected ff ff 1", got_w[0], got_x[0], got_last[0]);
            end
        end
        checks++;
        if (done_cyc != hs_first + 1 || done_cyc != 11) begin
            errors++; $display("FAIL single_done: got done on cycle %0d (handshake %0d) expected 11", done_cyc, hs_first);
        end
        checks++;
        if (w_log != exp_wa || x_log != exp_xa) begin
            errors++; $display("FAIL single_addrs: got %0d w reads %0d x reads expected 8 each from 0", w_log.size(), x_log.size());
        end
        bad_sel = 0;
        foreach (ws_log[i]) if (ws_log[i] != 2) bad_sel++;
        foreach (xs_log[i]) if (xs_log[i] != 0) bad_sel++;
        checks++;
        if (bad_sel != 0 || post_done !== 1'b0 || post_busy !== 1'b0) begin
            errors++; $display("FAIL single_sel_post: got %0d bad selects, done after=%b busy after=%b expected 0 0 0", bad_sel, post_done, post_busy);
        end
    endtask

    task automatic test_multi;
        int nbad;
        mem_mode = 1;
        build_model(2, 2, 1, 3);
        run_fetch(2, 2, 1, 3, 100, -1, 1'b0);
        nbad = 0;
        foreach (got_w[i])
            if (i >= exp_w.size() || got_w[i] !== 8'h55 || got_x[i] !== 8'h55 || got_last[i] !== exp_last[i]) nbad++;
        checks++;
        if (got_w.size() != 4 || nbad != 0) begin
            errors++; $display("FAIL multi_beats: got %0d beats with %0d bad expected 4 beats of 55 with last on 2 and 4", got_w.size(), nbad);
        end
        checks++;
        if (w_log != exp_wa) begin
            errors++; $display("FAIL multi_waddr: got %0d weight reads expected 32 continuous from 0", w_log.size());
        end
        checks++;
        if (x_log != exp_xa) begin
            errors++; $display("FAIL multi_xaddr: got %0d input reads expected 0..15 twice", x_log.size());
        end
        checks++;
        if (rq_bad != 0 || done_cnt != 1) begin
            errors++; $display("FAIL multi_protocol: got %0d stray requests, %0d done pulses expected 0 and 1", rq_bad, done_cnt);
        end
    endtask

    task automatic test_stall;
        mem_mode = 2;
        mem_seed = $urandom;
        build_model(1, 2, 3, 1);
        run_fetch(1, 2, 3, 1, 100, 0, 1'b0);
        checks++;
        if (stall_seen != 5 || stall_err != 0) begin
            errors++; $display("FAIL stall_hold: got %0d held cycles with %0d changes expected 5 with 0", stall_seen, stall_err);
        end
        checks++;
        if (rq_bad != 0) begin
            errors++; $display("FAIL stall_reads: got %0d requests during hold expected 0", rq_bad);
        end
        checks++;
        if (got_w != exp_w || got_x != exp_x || got_last != exp_last) begin
            errors++; $display("FAIL stall_data: got %0d beats first w=%h expected %0d beats first w=%h",
                               got_w.size(), (got_w.size() > 0) ? got_w[0] : 8'h0, exp_w.size(), exp_w[0]);
        end
    endtask

    task automatic test_empty;
        for (int t = 0; t < 2; t++) begin
            run_fetch((t == 0) ? 3 : 0, (t == 0) ? 0 : 2, 1, 1, 100, -1, 1'b0);
            checks++;
            if (done_cyc != 1 || w_log.size() != 0 || x_log.size() != 0 || got_w.size() != 0) begin
                errors++; $display("FAIL empty_%0d: got done cycle %0d, %0d/%0d reads, %0d beats expected 1, 0/0, 0",
                                   t, done_cyc, w_log.size(), x_log.size(), got_w.size());
            end
            checks++;
            if (post_done !== 1'b0 || post_busy !== 1'b0) begin
                errors++; $display("FAIL empty_post_%0d: got done=%b busy=%b expected 0 0", t, post_done, post_busy);
            end
        end
    endtask

    task automatic test_reset_mid;
        int   guard;
        logic hit;
        mem_mode = 0;
        bus.start = 1'b1; bus.n_neurons = 10'd2; bus.x_beats = 7'd2; bus.w_bank = 2'd1; bus.x_bank = 2'd3;
        guard = 0; hit = 1'b0;
        while (!hit && guard < 50) begin
            @(negedge clk);
            guard++;
            bus.start = 1'b0;
            if (bus.w_rq === 1'b1 && bus.w_addr === w_addr_t'(4)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rstmid_reach: got no request at address 4 within %0d cycles expected one", guard);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.w_rq, bus.x_rq, bus.w_addr, bus.x_addr, bus.w_sel, bus.x_sel, bus.out_valid,
             bus.out_w, bus.out_x, bus.out_last, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got w_rq=%b w_addr=%h x_addr=%h out_w=%h busy=%b done=%b expected all 0",
                     bus.w_rq, bus.w_addr, bus.x_addr, bus.out_w, bus.busy, bus.done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_w !== '0 || bus.out_x !== '0 || bus.w_rq !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got done=%b busy=%b out_w=%h out_x=%h w_rq=%b expected 0 0 00 00 0",
                               bus.done, bus.busy, bus.out_w, bus.out_x, bus.w_rq);
        end
        build_model(1, 1, 1, 3);
        run_fetch(1, 1, 1, 3, 100, -1, 1'b0);
        checks++;
        if (w_log != exp_wa || got_w != exp_w || done_cnt != 1) begin
            errors++; $display("FAIL rstmid_restart: got first w_addr=%0d, %0d beats, %0d dones expected 0, 1, 1",
                               (w_log.size() > 0) ? w_log[0] : 32'hFFFFFFFF, got_w.size(), done_cnt);
        end
    endtask

    task automatic test_restart_ignored;
        mem_mode = 2;
        mem_seed = $urandom;
        build_model(2, 3, 0, 2);
        run_fetch(2, 3, 0, 2, 60, 1, 1'b1);
        checks++;
        if (got_w != exp_w || got_x != exp_x || got_last != exp_last) begin
            errors++; $display("FAIL restart_beats: got %0d beats expected %0d matching the model", got_w.size(), exp_w.size());
        end
        checks++;
        if (w_log != exp_wa || x_log != exp_xa || done_cnt != 1 || rq_bad != 0) begin
            errors++; $display("FAIL restart_reads: got %0d/%0d reads, %0d dones, %0d stray expected %0d/%0d, 1, 0",
                               w_log.size(), x_log.size(), done_cnt, rq_bad, exp_wa.size(), exp_xa.size());
        end
    endtask

    task automatic test_random;
        int unsigned n, xb, wb, xbk;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 3); xb = $urandom_range(1, 4);
            wb = $urandom_range(0, 3); xbk = $urandom_range(0, 3);
            mem_mode = 2;
            mem_seed = $urandom;
            build_model(n, xb, wb, xbk);
            run_fetch(n, xb, wb, xbk, 50, -1, 1'b0);
            checks++;
            if (timeout != 0 || got_w != exp_w || got_x != exp_x || got_last != exp_last) begin
                errors++; $display("FAIL random_beats_%0d: n=%0d xb=%0d got %0d beats timeout=%0d expected %0d beats",
                                   t, n, xb, got_w.size(), timeout, exp_w.size());
            end
            checks++;
            if (w_log != exp_wa || x_log != exp_xa || rq_bad != 0 || post_done !== 1'b0) begin
                errors++; $display("FAIL random_reads_%0d: got %0d/%0d reads, %0d stray, done after=%b expected %0d/%0d, 0, 0",
                                   t, w_log.size(), x_log.size(), rq_bad, post_done, exp_wa.size(), exp_xa.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.w_bank = '0; bus.x_bank = '0; bus.n_neurons = '0; bus.x_beats = '0;
        bus.out_ready = 1'b0;
        mem_mode = 0; mem_seed = 32'd1;
        repeat (2) @(negedge clk);
        test_reset;
        test_single;
        test_multi;
        test_stall;
        test_empty;
        test_reset_mid;
        test_restart_ignored;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
